// File: rtl/calc_engine.sv
// Multi-cycle unsigned arithmetic engine: single-cycle add/sub, iterative
// shift-add multiply and restoring divide, with a start/busy/done handshake.
module calc_engine #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 use_acc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

    state_t               state_q;
    op_t                  op_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 dbz_q;

    logic [WIDTH-1:0]     opa;
    logic [2*WIDTH-1:0]   add_res;
    logic [2*WIDTH-1:0]   sub_res;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   acc_d;

    // acc_q holds {partial product high, multiplier} for mul and
    // {remainder, dividend/quotient} for div; opnd_q is multiplicand or divisor.
    always_comb begin
        opa       = use_acc ? result_q[WIDTH-1:0] : a;
        add_res   = {{WIDTH{1'b0}}, opa} + {{WIDTH{1'b0}}, b};
        sub_res   = {{WIDTH{1'b0}}, opa} - {{WIDTH{1'b0}}, b};
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (op_q == OP_MUL) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op_t'(op);
                        cnt_q <= '0;
                        case (op_t'(op))
                            OP_ADD: begin
                                result_q <= add_res;
                                dbz_q    <= 1'b0;
                                state_q  <= S_DONE;
                            end
                            OP_SUB: begin
                                result_q <= sub_res;
                                dbz_q    <= 1'b0;
                                state_q  <= S_DONE;
                            end
                            OP_MUL: begin
                                acc_q   <= {{WIDTH{1'b0}}, b};
                                opnd_q  <= opa;
                                state_q <= S_RUN;
                            end
                            default: begin
                                if (b == '0) begin
                                    result_q <= {opa, {WIDTH{1'b1}}};
                                    dbz_q    <= 1'b1;
                                    state_q  <= S_DONE;
                                end else begin
                                    acc_q   <= {{WIDTH{1'b0}}, opa};
                                    opnd_q  <= b;
                                    state_q <= S_RUN;
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_q <= acc_d;
                        dbz_q    <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine at WIDTH=8 and WIDTH=32.
module tb_calc_engine;

    logic        clk;
    logic        rst_n;

    logic        start8, use_acc8, busy8, done8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    logic        start32, use_acc32, busy32, done32, dbz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic [63:0] res32;

    int checks   = 0;
    int failures = 0;

    calc_engine #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .use_acc(use_acc8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8), .div_by_zero(dbz8)
    );

    calc_engine #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .use_acc(use_acc32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .result(res32), .div_by_zero(dbz32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 8-bit engine, scramble inputs after acceptance,
    // and check latency, result, flag and the return to idle.
    task automatic run8(input string tag, input logic [1:0] o, input logic ua,
                        input logic [7:0] av, input logic [7:0] bv,
                        input int lat, input logic [15:0] er, input logic edz);
        int cyc;
        @(negedge clk);
        start8 = 1'b1; op8 = o; use_acc8 = ua; a8 = av; b8 = bv;
        @(negedge clk);
        start8 = 1'b0; op8 = ~o; use_acc8 = ~ua; a8 = 8'hA5; b8 = 8'h5A;
        cyc = 1;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_busy"}, 64'(busy8), 64'd1);
        check({tag, "_res"}, 64'(res8), 64'(er));
        check({tag, "_dbz"}, 64'(dbz8), 64'(edz));
        @(negedge clk);
        check({tag, "_done_low"}, 64'(done8), 64'd0);
        check({tag, "_idle"}, 64'(busy8), 64'd0);
        check({tag, "_hold"}, 64'(res8), 64'(er));
    endtask

    initial begin
        int first_done;
        int n_done;
        logic [63:0] cap32;

        rst_n = 1'b0;
        start8 = 1'b0; op8 = 2'b00; use_acc8 = 1'b0; a8 = '0; b8 = '0;
        start32 = 1'b0; op32 = 2'b00; use_acc32 = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_res8", 64'(res8), 64'd0);
        check("rst_dbz8", 64'(dbz8), 64'd0);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_res32", res32, 64'd0);
        rst_n = 1'b1;

        run8("add", 2'b00, 1'b0, 8'd200, 8'd100, 1, 16'h012C, 1'b0);
        run8("sub_borrow", 2'b01, 1'b0, 8'd3, 8'd5, 1, 16'hFFFE, 1'b0);
        run8("div", 2'b11, 1'b0, 8'd100, 8'd7, 9, 16'h020E, 1'b0);
        run8("div0", 2'b11, 1'b0, 8'd55, 8'd0, 1, 16'h37FF, 1'b1);
        run8("add_clr", 2'b00, 1'b0, 8'd1, 8'd1, 1, 16'h0002, 1'b0);
        run8("mul_max", 2'b10, 1'b0, 8'd255, 8'd255, 9, 16'hFE01, 1'b0);
        run8("div_small", 2'b11, 1'b0, 8'd5, 8'd9, 9, 16'h0500, 1'b0);
        run8("div_by1", 2'b11, 1'b0, 8'd255, 8'd1, 9, 16'h00FF, 1'b0);
        run8("acc_add", 2'b00, 1'b0, 8'd10, 8'd5, 1, 16'h000F, 1'b0);
        run8("acc_mul", 2'b10, 1'b1, 8'd99, 8'd3, 9, 16'h002D, 1'b0);
        run8("acc_sub", 2'b01, 1'b1, 8'd99, 8'd50, 1, 16'hFFFB, 1'b0);

        // 32-bit multiply with start re-pulsed while busy
        @(negedge clk);
        start32 = 1'b1; op32 = 2'b10; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        first_done = 0; n_done = 0; cap32 = '0;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                a32 = 32'd3; b32 = 32'd4; op32 = 2'b00;
            end
            if (done32) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = cyc;
                    cap32 = res32;
                end
            end
            start32 = (cyc <= 33) && (cyc % 2 == 1);
        end
        check("mul32_lat", 64'(first_done), 64'd33);
        check("mul32_ndone", 64'(n_done), 64'd1);
        check("mul32_res", cap32, 64'hFFFF_FFFE_0000_0001);
        check("mul32_idle", 64'(busy32), 64'd0);

        // Reset asserted in cycle 4 of an 8-bit multiply
        @(negedge clk);
        start8 = 1'b1; op8 = 2'b10; use_acc8 = 1'b0; a8 = 8'd12; b8 = 8'd13;
        n_done = 0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) n_done++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_busy", 64'(busy8), 64'd0);
        check("rstmid_res", 64'(res8), 64'd0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (done8 || busy8) n_done++;
            @(negedge clk);
        end
        check("rstmid_nodone", 64'(n_done), 64'd0);
        run8("post_rst_add", 2'b00, 1'b0, 8'd2, 8'd3, 1, 16'h0005, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
